mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency memory between the CPU instruction-fetch port and data (load/store) port.
- Needed when instruction and data memories are merged into one array, e.g. for a multicycle or pipelined variant of the CPU datapath.
- Sits between the fetch logic, the load/store path and the memory.
- Fixed priority to data, with a starvation guard for fetch.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/arb_starve_ctr.sv | 36 +++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the instruction/data memory arbiter:
//   FSM state encoding, grant identifiers and the width of the small
//   latency / starvation counters.
//   Ports: none (package).
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // Wide enough for MEM_LAT and STARVE_MAX up to 15.
    localparam int LAT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr
//   Saturating count of consecutive data grants made while fetch waits.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     inc       - data grant while if_req is high (saturates at MAX)
//     clr       - fetch grant, or idle cycle with no fetch request
//     at_max    - counter has reached MAX; fetch must win next grant
module arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [LAT_W-1:0] MAX_V = LAT_W'(MAX);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port fixed-latency memory between the instruction
//   fetch port and the data (load/store) port. Data has fixed priority;
//   after STARVE_MAX consecutive data grants with fetch waiting, fetch wins.
//   One access is in flight at a time: IDLE -> WAIT -> RESP -> IDLE.
//   Ports:
//     clk, rst                         - clock, synchronous active-high reset
//     if_req/if_addr -> if_ack/if_rdata - fetch port
//     d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata - data port
//     mem_en/mem_we/mem_addr/mem_wdata, mem_rdata - memory side
//     busy                             - state is not IDLE
//     perf_if_stall, perf_d_stall      - only with MEM_ARBITER_PERF_EN
//   Handshake: a requester holds req and payload until its one-cycle ack;
//   the arbiter ignores a req sampled during that requester's own ack cycle.
//   Optional feature macro: MEM_ARBITER_PERF_EN (saturating stall counters).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_d_stall
`endif
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              mem_en_d, mem_we_d, if_ack_d, d_ack_d, busy_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;

    logic grant_d, grant_if;
    logic starve_inc, starve_clr, starve_at_max;

    // Data wins unless fetch is waiting and has been passed over too often.
    assign grant_d  = (state_q == IDLE) && d_req && !(if_req && starve_at_max);
    assign grant_if = (state_q == IDLE) && if_req && !grant_d;

    assign starve_inc = grant_d && if_req;
    assign starve_clr = grant_if || ((state_q == IDLE) && !if_req);

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        lat_d       = lat_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = WAIT;
                    gnt_d       = GNT_D;
                    we_d        = d_we;
                    lat_d       = LAT_LOAD;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_if) begin
                    state_d     = WAIT;
                    gnt_d       = GNT_IF;
                    we_d        = 1'b0;
                    lat_d       = LAT_LOAD;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            WAIT: begin
                // lat_q equals MEM_LAT in the strobe cycle, so zero marks
                // the cycle in which mem_rdata is valid.
                if (lat_q == '0) begin
                    state_d = RESP;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_IF;
            we_q      <= 1'b0;
            lat_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            lat_q     <= lat_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_ack    <= if_ack_d;
            d_ack     <= d_ack_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            busy      <= busy_d;
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    // A port stalls when it requests but is neither granted this cycle
    // nor the owner of the access currently in flight.
    logic if_serv, d_serv;
    assign if_serv = (state_q != IDLE) && (gnt_q == GNT_IF);
    assign d_serv  = (state_q != IDLE) && (gnt_q == GNT_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
        end else begin
            if (if_req && !grant_if && !if_serv && (perf_if_stall != '1)) begin
                perf_if_stall <= perf_if_stall + 1'b1;
            end
            if (d_req && !grant_d && !d_serv && (perf_d_stall != '1)) begin
                perf_d_stall <= perf_d_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter with MEM_LAT=2, STARVE_MAX=4.
//   A bench memory answers each strobe MEM_LAT cycles later; expected
//   strobes and acks are queued when stimulus is driven and compared by
//   a monitor on the falling edge.
//   Optional feature macro: MEM_ARBITER_PERF_EN (checks stall counters).
module tb_mem_arbiter;

    localparam int L  = 2;
    localparam int SM = 4;
    localparam int P  = L + 3;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        int          cyc;
    } ack_exp_t;

    typedef struct {
        logic        fi;
        logic [31:0] fa;
        logic        di;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'hBAD0_BAD0;
    logic        busy;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_d_stall;
`endif

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LAT    (L),
        .STARVE_MAX (SM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
`ifdef MEM_ARBITER_PERF_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_d_stall  (perf_d_stall)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_d_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- bench memory (responder) ----------------
    logic [31:0] rsp_mem [64];
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 32'hA500_0000 | (i * 32'h0001_0101);
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++) rsp_mem[i] = ref_mem[i];
    end

    // Read data is presented only in the strobe cycle + L; garbage otherwise.
    always @(negedge clk) begin
        mem_rdata = 32'hBAD0_BAD0;
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                mem_rdata = pend_data;
                pend = 1'b0;
            end
        end
        if (mem_en) begin
            pend      = 1'b1;
            pend_cnt  = L;
            pend_data = rsp_mem[mem_addr[7:2]];
            if (mem_we) rsp_mem[mem_addr[7:2]] = mem_wdata;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_en", {31'd0, mem_en}, 32'd0);
                end else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    chk("mem_en_cycle", cyc, m.cyc);
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
            if (if_ack || d_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", {30'd0, if_ack, d_ack}, 32'd0);
                end else begin
                    ack_exp_t a;
                    a = ack_q.pop_front();
                    chk("ack_port", {30'd0, if_ack, d_ack}, a.is_d ? 32'd1 : 32'd2);
                    chk("ack_cycle", cyc, a.cyc);
                    if (a.is_d) chk("d_rdata", d_rdata, a.data);
                    else        chk("if_rdata", if_rdata, a.data);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_access(input logic is_d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int en_c);
        mem_exp_t m;
        ack_exp_t a;
        m.addr = addr; m.we = we; m.wdata = wdata; m.cyc = en_c;
        mem_q.push_back(m);
        a.is_d = is_d;
        a.cyc  = en_c + 1 + L;
        if (we) begin
            ref_mem[addr[7:2]] = wdata;
            a.data = exp_d_rdata;
        end else begin
            a.data = ref_mem[addr[7:2]];
            if (is_d) exp_d_rdata = a.data;
        end
        ack_q.push_back(a);
    endtask

    // Launch one fetch and/or one data request from an idle arbiter (starve
    // count 0, so data goes first) and follow it to completion.
    task automatic run_pair(input vec_t v);
        int k, nacc, off, slot;
        logic eb;
        @(negedge clk);
        k = cyc;
        nacc = 0;
        if (v.di) begin
            push_access(1'b1, v.dwe, v.da, v.dwd, k + 1);
            nacc++;
        end
        if (v.fi) begin
            push_access(1'b0, 1'b0, v.fa, 32'd0, k + 1 + nacc * P);
            nacc++;
        end
        if_req = v.fi; if_addr = v.fa;
        d_req = v.di; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
        chk("busy_at_req", {31'd0, busy}, 32'd0);
        for (int c = k + 1; c <= k + nacc * P; c++) begin
            @(negedge clk);
            off  = (c - k - 1) % P;
            slot = (c - k - 1) / P;
            eb   = (slot < nacc) && (off <= L + 1);
            chk("busy", {31'd0, busy}, {31'd0, eb});
            if (if_ack) if_req = 1'b0;
            if (d_ack)  d_req  = 1'b0;
        end
        chk("reqs_acked", {30'd0, if_req, d_req}, 32'd0);
        if_req = 1'b0; d_req = 1'b0;
    endtask

    vec_t vecs [8];
    int   pi0, pd0, k, nack;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst_mem_ctl", {29'd0, mem_en, mem_we, busy}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
`ifdef MEM_ARBITER_PERF_EN
        chk("rst_perf_if", perf_if_stall, 32'd0);
        chk("rst_perf_d", perf_d_stall, 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch alone: strobe at cycle 1, ack at cycle 4 with 0xDEADBEEF.
        run_pair('{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0});
        // Store: d_rdata stays at its reset value 0.
        run_pair('{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678});

        // Simultaneous fetch and load: data first, fetch strobe at cycle 6.
`ifdef MEM_ARBITER_PERF_EN
        pi0 = perf_if_stall;
        pd0 = perf_d_stall;
`endif
        run_pair('{1'b1, 32'h14, 1'b1, 1'b0, 32'h40, 32'h0});
`ifdef MEM_ARBITER_PERF_EN
        // Fetch waits in cycles 0..4 (data granted, then in service) and is
        // granted in cycle 5; data is granted immediately.
        chk("perf_if_stall", perf_if_stall - pi0, 32'd5);
        chk("perf_d_stall", perf_d_stall - pd0, 32'd0);
`endif

        // Table of mixed vectors
        vecs[0] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h20, 32'h0};
        vecs[1] = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 32'h24, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[3] = '{1'b1, 32'h28, 1'b1, 1'b1, 32'h28, 32'h5555_AAAA};
        vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hFC, 32'h0};
        for (int i = 5; i < 8; i++) begin
            vecs[i].fi  = 1'($urandom_range(0, 1));
            vecs[i].di  = vecs[i].fi ? 1'($urandom_range(0, 1)) : 1'b1;
            vecs[i].dwe = 1'($urandom_range(0, 1));
            vecs[i].fa  = 32'($urandom_range(0, 63)) << 2;
            vecs[i].da  = 32'($urandom_range(0, 63)) << 2;
            vecs[i].dwd = $urandom;
        end
        for (int i = 0; i < 8; i++) begin
            run_pair(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Starvation: both held; grants D,D,D,D,IF,D.
        @(negedge clk);
        k = cyc;
        for (int i = 0; i < 6; i++) begin
            if ((i % (SM + 1)) == SM) push_access(1'b0, 1'b0, 32'h30, 32'd0, k + 1 + i * P);
            else                      push_access(1'b1, 1'b0, 32'h34, 32'd0, k + 1 + i * P);
        end
        if_req = 1'b1; if_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34;
        nack = 0;
        for (int c = 0; c < 6 * P + 2 && nack < 6; c++) begin
            @(negedge clk);
            if (if_ack || d_ack) nack++;
            if (nack == 6) begin
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        chk("starve_acks", nack, 32'd6);
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("starve_idle", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        // Request dropped after one cycle: access still completes.
        @(negedge clk);
        k = cyc;
        push_access(1'b1, 1'b0, 32'h08, 32'd0, k + 1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
        @(negedge clk);
        d_req = 1'b0; d_addr = 32'hFFFF_FFF0;
        repeat (P + 1) @(negedge clk);
        chk("dropped_req_acked", ack_q.size(), 32'd0);

        // Reset during WAIT: no ack, outputs cleared next cycle.
        @(negedge clk);
        k = cyc;
        push_access(1'b0, 1'b0, 32'h0C, 32'd0, k + 1);
        void'(ack_q.pop_back());
        if_req = 1'b1; if_addr = 32'h0C;
        repeat (2) @(negedge clk);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        chk("rst_wait_busy", {31'd0, busy}, 32'd0);
        chk("rst_wait_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_wait_ack", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst_wait_if_rdata", if_rdata, 32'd0);
        chk("rst_wait_d_rdata", d_rdata, 32'd0);
        exp_d_rdata = '0;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_wait_no_strobe", mem_q.size(), 32'd0);

        // Fresh fetch after reset with standard latency.
        run_pair('{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0});
        repeat (2) @(negedge clk);
        chk("queues_drained", mem_q.size() + ack_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
